tb_irq_ctrl: RTL and testbench
==============================

Name: tb_irq_ctrl

Overview:
Memory-mapped interrupt generator for the core testbench. It sits between the data-bus address decoder and the core's exploded interrupt inputs. It holds pending bits for software, timer, external, fast, NMI and fastx lines, which test programs set through register writes or a countdown timer. Pending bits are cleared by the core's irq_ack_i/irq_id_i handshake or by register writes.

Parameters:
TIMER_WIDTH, 32, width of the countdown timer (1..32). Bits above TIMER_WIDTH-1 read 0 and are ignored on write.
ADDR_WIDTH, 8, width of the register-window address slice.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  bus request (already decoded to this window)
addr_i  in  ADDR_WIDTH  byte address; only addr_i[5:2] is decoded
we_i  in  1  write enable
be_i  in  4  byte enables
wdata_i  in  32  write data
rdata_o  out  32  read data, valid when rvalid_o=1
gnt_o  out  1  grant
rvalid_o  out  1  response valid
irq_id_i  in  5  ID of the interrupt being acknowledged
irq_ack_i  in  1  ack strobe, one cycle
irq_software_o  out  1  pending bit 3
irq_timer_o  out  1  pending bit 7
irq_external_o  out  1  pending bit 11
irq_fast_o  out  15  pending bits 30:16
irq_nmi_o  out  1  pending bit 31
irq_fastx_o  out  32  fastx pending register

Behaviour:
- Reset, asynchronous, active-low:
  - All irq outputs 0, rdata_o=0, rvalid_o=0.
  - All registers 0.
  - Timer disabled.
- Bus protocol:
  - gnt_o=req_i, combinational, no stalls.
  - rvalid_o=1 exactly one cycle after each granted request, for both reads and writes.
  - rdata_o carries the read value in the rvalid_o cycle and is 0 otherwise.
  - be_i masks writes per byte on every writable register.
- Register map (word offsets):
  - 0x00 PEND: RW; only bits 3, 7, 11 and 30:16 plus 31 are implemented, all others read 0.
  - 0x04 PEND_SET: W1S.
  - 0x08 PEND_CLR: W1C.
  - 0x0C FASTX: RW.
  - 0x10 FASTX_SET: W1S.
  - 0x14 FASTX_CLR: W1C.
  - 0x18 TIMER_CMP: RW. A write also loads TIMER_CNT with the new value.
  - 0x1C TIMER_CNT: RO.
  - 0x20 CTRL: bit0 ENABLE, bit1 AUTO_RELOAD.
  - 0x24 RAND_MASK: see Optional Feature.
  - Unmapped offsets read 0; writes to them are ignored.
  - SET/CLR offsets read 0.
- Outputs are the pending registers driven directly, so they are registered. A write in cycle N shows on the irq outputs in cycle N+1.
- Timer:
  - Counts only while ENABLE=1 and TIMER_CNT!=0; decrements by 1 per cycle.
  - On the 1->0 transition, pending bit 7 is set.
  - If AUTO_RELOAD=1 and TIMER_CMP!=0, TIMER_CNT reloads TIMER_CMP on the cycle after reaching 0. The period is therefore CMP+1 cycles.
  - TIMER_CMP=0 means no expiry.
  - A TIMER_CMP write while the timer is running reloads the count without firing.
- Acknowledge:
  - When irq_ack_i=1, the pending bit at index irq_id_i is cleared if that bit is implemented.
  - IDs of unimplemented bits are ignored.
  - The ack does not affect fastx.
- Simultaneous events on the same bit in the same cycle: set (SET write, timer expiry, random inject) beats clear (ack, CLR write).
- Direct writes to PEND/FASTX take effect first; SET/ack/timer are then applied on top.
- Ack and a bus write in the same cycle: both take effect, subject to the priority rule above.
- Reset asserted mid-transaction:
  - The outstanding rvalid is dropped.
  - All state returns to reset values immediately, without waiting for a clock edge.

Optional Feature:
TB_IRQ_RANDOM_EN
- Defined:
  - A 32-bit Galois LFSR (polynomial 0x80200003, reset seed 0xACE10001) advances every cycle.
  - When lfsr[7:0]==0, the pending bits (lfsr & RAND_MASK & implemented-bit mask) are set.
  - RAND_MASK is RW at 0x24 and resets to 0.
- Undefined:
  - No LFSR.
  - 0x24 reads 0 and writes to it are ignored.
  - No random injection.

Test Plan:
1. Write PEND_SET=0x00000808 -> irq_software_o=1 and irq_external_o=1 one cycle later. Then irq_ack_i=1 with irq_id_i=3 -> irq_software_o=0 next cycle; irq_external_o stays 1.
2. TIMER_CMP=5, CTRL=0x1 -> irq_timer_o rises 6 cycles after CTRL's write cycle and fires once. With CTRL=0x3, CMP=5 -> irq_timer_o sets every 6 cycles; the ack clears it between firings.
3. Ack of id 7 in the same cycle as timer expiry -> irq_timer_o stays 1 (set wins).
4. Write FASTX=0xFFFFFFFF with be_i=0x3 -> readback 0x0000FFFF, irq_fastx_o=0x0000FFFF. Then FASTX_CLR=0x1 -> 0x0000FFFE. An ack with irq_id_i=0 leaves it unchanged.
5. Back-to-back reads of 0x00, 0x1C and unmapped 0x3C -> gnt_o=1 each cycle, rvalid_o=1 in three consecutive cycles, 0x3C returns 0.
6. Assert rst_ni low mid-count (TIMER_CNT=3) with pending bits set -> all irq outputs and rvalid_o go to 0 asynchronously. After release, TIMER_CNT=0 and no timer interrupt fires.

Source files
------------

// File: rtl/tb_irq_ctrl.sv
// Memory-mapped interrupt generator for the core bench: pending bits, fastx lines and a countdown timer.
// Optional random injection via an LFSR when TB_IRQ_RANDOM_EN is defined.
module tb_irq_ctrl #(
  parameter int TIMER_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  input  logic [4:0]            irq_id_i,
  input  logic                  irq_ack_i,
  output logic                  irq_software_o,
  output logic                  irq_timer_o,
  output logic                  irq_external_o,
  output logic [14:0]           irq_fast_o,
  output logic                  irq_nmi_o,
  output logic [31:0]           irq_fastx_o
);

  localparam logic [31:0] IMPL  = 32'hFFFF_0888;
  localparam logic [31:0] TMASK = 32'hFFFF_FFFF >> (32 - TIMER_WIDTH);

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [3:0]  off;
    logic [31:0] bm;
    logic [31:0] wd;
  } bus_req_t;

  bus_req_t    breq;
  logic [31:0] pend, fastx, cmp, cnt;
  logic        en, arl;
  logic [31:0] pend_n, fastx_n, cmp_n, cnt_n, rd_val, set_m, clr_m, rand_set;
  logic        fire;
  logic        unused_addr;

  assign unused_addr = ^{addr_i[ADDR_WIDTH-1:6], addr_i[1:0]};

  assign breq.wr  = req_i & we_i;
  assign breq.rd  = req_i & ~we_i;
  assign breq.off = addr_i[5:2];
  assign breq.bm  = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign breq.wd  = wdata_i & breq.bm;
  assign gnt_o    = req_i;

  function automatic logic [31:0] merge(input logic [31:0] old, input bus_req_t r);
    return (old & ~r.bm) | r.wd;
  endfunction

`ifdef TB_IRQ_RANDOM_EN
  logic [31:0] lfsr, rand_mask;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr      <= 32'hACE1_0001;
      rand_mask <= '0;
    end else begin
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 32'h8020_0003) : (lfsr >> 1);
      if (breq.wr && breq.off == 4'h9) rand_mask <= merge(rand_mask, breq);
    end
  end

  assign rand_set = (lfsr[7:0] == 8'h00) ? (lfsr & rand_mask & IMPL) : '0;
`else
  assign rand_set = '0;
`endif

  always_comb begin
    cmp_n = cmp;
    cnt_n = cnt;
    fire  = 1'b0;
    // A compare write reloads the count and suppresses any expiry that cycle.
    if (breq.wr && breq.off == 4'h6) begin
      cmp_n = merge(cmp, breq) & TMASK;
      cnt_n = cmp_n;
    end else if (en && cnt != '0) begin
      cnt_n = (cnt - 32'd1) & TMASK;
      fire  = (cnt == 32'd1);
    end else if (en && arl && cmp != '0) begin
      cnt_n = cmp;
    end
  end

  // Direct writes land first, then clears, then sets so a set wins on collision.
  always_comb begin
    pend_n = pend;
    if (breq.wr && breq.off == 4'h0) pend_n = merge(pend, breq);
    clr_m = (irq_ack_i ? (32'h1 << irq_id_i) : '0)
          | ((breq.wr && breq.off == 4'h2) ? breq.wd : '0);
    set_m = ((breq.wr && breq.off == 4'h1) ? breq.wd : '0)
          | (fire ? 32'h0000_0080 : '0) | rand_set;
    pend_n = ((pend_n & ~clr_m) | set_m) & IMPL;

    fastx_n = fastx;
    if (breq.wr && breq.off == 4'h3) fastx_n = merge(fastx, breq);
    if (breq.wr && breq.off == 4'h5) fastx_n = fastx_n & ~breq.wd;
    if (breq.wr && breq.off == 4'h4) fastx_n = fastx_n | breq.wd;
  end

  always_comb begin
    rd_val = '0;
    case (breq.off)
      4'h0: rd_val = pend;
      4'h3: rd_val = fastx;
      4'h6: rd_val = cmp;
      4'h7: rd_val = cnt;
      4'h8: rd_val = {30'd0, arl, en};
`ifdef TB_IRQ_RANDOM_EN
      4'h9: rd_val = rand_mask;
`endif
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend     <= '0;
      fastx    <= '0;
      cmp      <= '0;
      cnt      <= '0;
      en       <= 1'b0;
      arl      <= 1'b0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      pend     <= pend_n;
      fastx    <= fastx_n;
      cmp      <= cmp_n;
      cnt      <= cnt_n;
      rvalid_o <= req_i;
      rdata_o  <= breq.rd ? rd_val : '0;
      if (breq.wr && breq.off == 4'h8 && be_i[0]) begin
        en  <= wdata_i[0];
        arl <= wdata_i[1];
      end
    end
  end

  assign irq_software_o = pend[3];
  assign irq_timer_o    = pend[7];
  assign irq_external_o = pend[11];
  assign irq_fast_o     = pend[30:16];
  assign irq_nmi_o      = pend[31];
  assign irq_fastx_o    = fastx;

endmodule

// File: tb/tb_tb_irq_ctrl.sv
// Randomized + directed bench for tb_irq_ctrl against a cycle-level behavioural model.
module tb_tb_irq_ctrl;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        req = 1'b0, we = 1'b0, ack = 1'b0;
  logic [7:0]  addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  id = '0;
  logic [31:0] rdata_o, irq_fastx_o;
  logic        gnt_o, rvalid_o, irq_software_o, irq_timer_o, irq_external_o, irq_nmi_o;
  logic [14:0] irq_fast_o;

  int checks = 0, errors = 0;

  logic [31:0] m_pend, m_fastx, m_cmp, m_cnt, e_rd, impl;
  bit          m_en, m_arl, e_rv;

  tb_irq_ctrl #(.TIMER_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .rdata_o(rdata_o), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .irq_id_i(id), .irq_ack_i(ack), .irq_software_o(irq_software_o), .irq_timer_o(irq_timer_o),
    .irq_external_o(irq_external_o), .irq_fast_o(irq_fast_o), .irq_nmi_o(irq_nmi_o),
    .irq_fastx_o(irq_fastx_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] out_pend();
    return {irq_nmi_o, irq_fast_o, 4'b0, irq_external_o, 3'b0, irq_timer_o, 3'b0, irq_software_o, 3'b0};
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] o);
    case (o)
      4'h0: return m_pend;
      4'h3: return m_fastx;
      4'h6: return m_cmp;
      4'h7: return m_cnt;
      4'h8: return {30'd0, m_arl, m_en};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_pend = 0; m_fastx = 0; m_cmp = 0; m_cnt = 0; m_en = 0; m_arl = 0; e_rv = 0; e_rd = 0;
  endtask

  // One clock: predict from the current inputs, advance, compare everything visible.
  task automatic cycle();
    logic [31:0] bm, wd, np, nf, ncmp, ncnt, setm, clrm, rd_exp;
    logic [3:0]  o;
    bit          wr, fire, nen, narl;
    #1 chk("gnt", {31'd0, gnt_o}, {31'd0, req});
    o  = addr[5:2];
    wr = req && we;
    for (int b = 0; b < 4; b++) bm[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
    wd     = wdata & bm;
    rd_exp = (req && !we) ? m_read(o) : 32'd0;
    ncmp = m_cmp; ncnt = m_cnt; fire = 0;
    if (wr && o == 6) begin
      ncmp = (m_cmp & ~bm) | wd;
      ncnt = ncmp;
    end else if (m_en) begin
      if (m_cnt > 0) begin
        ncnt = m_cnt - 1;
        fire = (ncnt == 0);
      end else if (m_arl && m_cmp > 0) ncnt = m_cmp;
    end
    np = m_pend;
    if (wr && o == 0) np = (np & ~bm) | wd;
    clrm = 0; setm = 0;
    if (ack) clrm[id] = 1'b1;
    if (wr && o == 2) clrm |= wd;
    if (wr && o == 1) setm |= wd;
    if (fire) setm[7] = 1'b1;
    np = ((np & ~clrm) | setm) & impl;
    nf = m_fastx;
    if (wr && o == 3) nf = (nf & ~bm) | wd;
    if (wr && o == 5) nf &= ~wd;
    if (wr && o == 4) nf |= wd;
    nen = m_en; narl = m_arl;
    if (wr && o == 8 && be[0]) begin nen = wdata[0]; narl = wdata[1]; end
    @(posedge clk_i); #1;
    m_pend = np; m_fastx = nf; m_cmp = ncmp; m_cnt = ncnt; m_en = nen; m_arl = narl;
    e_rv = req; e_rd = rd_exp;
    chk("pend", out_pend(), m_pend);
    chk("fastx", irq_fastx_o, m_fastx);
    chk("rvalid", {31'd0, rvalid_o}, {31'd0, e_rv});
    chk("rdata", rdata_o, e_rd);
  endtask

  task automatic bus(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1; we = w; addr = a; wdata = d; be = b;
    cycle();
    req = 0; we = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_ack(input logic [4:0] i);
    ack = 1; id = i;
    cycle();
    ack = 0;
  endtask

  initial begin
    int k, last, nr;
    logic [31:0] r;
    logic [3:0]  o;
    impl = 0;
    impl[3] = 1; impl[7] = 1; impl[11] = 1;
    for (int i = 16; i < 32; i++) impl[i] = 1;
    m_reset();

    #12;
    chk("rst_pend", out_pend(), 0);
    chk("rst_fastx", irq_fastx_o, 0);
    chk("rst_rvalid", {31'd0, rvalid_o}, 0);
    chk("rst_rdata", rdata_o, 0);
    @(negedge clk_i) rst_ni = 1;
    @(posedge clk_i); #1;

    // Plan 1: software/external set, selective ack.
    bus(1, 8'h04, 32'h0000_0808, 4'hF);
    chk("t1_sw_set", {31'd0, irq_software_o}, 1);
    chk("t1_ext_set", {31'd0, irq_external_o}, 1);
    do_ack(5'd3);
    chk("t1_sw_clr", {31'd0, irq_software_o}, 0);
    chk("t1_ext_keep", {31'd0, irq_external_o}, 1);

    // Plan 2: one-shot latency, then auto-reload period.
    bus(1, 8'h18, 32'd5, 4'hF);
    bus(1, 8'h20, 32'd1, 4'hF);
    k = 1;
    while (!irq_timer_o && k < 20) begin idle(1); k++; end
    chk("t2_oneshot_lat", k, 6);
    idle(10);
    do_ack(5'd7);
    idle(10);
    chk("t2_no_refire", {31'd0, irq_timer_o}, 0);
    bus(1, 8'h20, 32'd3, 4'hF);
    last = -1; nr = 0;
    for (int c = 0; c < 40; c++) begin
      if (irq_timer_o) begin
        ack = 1; id = 5'd7;
        if (last >= 0) chk("t2_period", c - last, 6);
        last = c; nr++;
      end
      cycle();
      ack = 0;
    end
    chk("t2_fires", {31'd0, nr >= 5}, 1);

    // Plan 3: ack on the expiry cycle loses to the set.
    k = 0;
    while (m_cnt != 1 && k < 20) begin idle(1); k++; end
    chk("t3_reached", {31'd0, m_cnt == 1}, 1);
    do_ack(5'd7);
    chk("t3_set_wins", {31'd0, irq_timer_o}, 1);
    bus(1, 8'h20, 32'd0, 4'hF);
    do_ack(5'd7);

    // Plan 4: byte-masked FASTX, W1C, ack has no effect.
    bus(1, 8'h0C, 32'hFFFF_FFFF, 4'h3);
    bus(0, 8'h0C, 32'd0, 4'hF);
    chk("t4_rd", rdata_o, 32'h0000_FFFF);
    chk("t4_out", irq_fastx_o, 32'h0000_FFFF);
    bus(1, 8'h14, 32'h1, 4'hF);
    chk("t4_clr", irq_fastx_o, 32'h0000_FFFE);
    do_ack(5'd0);
    chk("t4_ack", irq_fastx_o, 32'h0000_FFFE);

    // Plan 5: back-to-back reads including an unmapped offset.
    bus(0, 8'h00, 32'd0, 4'hF);
    chk("t5_rv0", {31'd0, rvalid_o}, 1);
    req = 1;
    bus(0, 8'h1C, 32'd0, 4'hF);
    chk("t5_rv1", {31'd0, rvalid_o}, 1);
    bus(0, 8'h3C, 32'hDEAD_BEEF, 4'hF);
    chk("t5_rv2", {31'd0, rvalid_o}, 1);
    chk("t5_unmapped", rdata_o, 0);

    // Plan 6: asynchronous reset mid-count with an outstanding response.
    bus(1, 8'h04, 32'h8001_0808, 4'hF);
    bus(1, 8'h18, 32'd8, 4'hF);
    bus(1, 8'h20, 32'd1, 4'hF);
    k = 0;
    while (m_cnt != 4 && k < 20) begin idle(1); k++; end
    bus(0, 8'h1C, 32'd0, 4'hF);
    chk("t6_cnt_before", rdata_o, 4);
    #2 rst_ni = 0;
    #1;
    chk("t6_pend", out_pend(), 0);
    chk("t6_fastx", irq_fastx_o, 0);
    chk("t6_rvalid", {31'd0, rvalid_o}, 0);
    chk("t6_rdata", rdata_o, 0);
    m_reset();
    @(negedge clk_i) rst_ni = 1;
    @(posedge clk_i); #1;
    bus(0, 8'h1C, 32'd0, 4'hF);
    chk("t6_cnt_after", rdata_o, 0);
    idle(20);
    chk("t6_no_timer", {31'd0, irq_timer_o}, 0);

    // Randomized traffic with concurrent acks.
    for (int c = 0; c < 3000; c++) begin
      r = $urandom;
      o = (r[7:4] == 4'hF) ? 4'hF : 4'($urandom_range(0, 10));
      req = (r[1:0] != 2'b00);
      we = r[2];
      addr = {r[9:8], o, r[11:10]};
      be = 4'($urandom);
      wdata = $urandom;
      if (o == 4'h6) wdata = $urandom_range(0, 12);
      if (o == 4'h8) wdata = $urandom_range(0, 3);
      ack = (r[13:12] == 2'b00);
      id = (r[16:14] == 3'b000) ? 5'd7 : 5'($urandom);
      cycle();
    end
    req = 0; ack = 0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
